// File: rtl/counter_run_ctrl.sv
// Run/stop sequencer for the board up-counter: issues a clear, gates the
// enable, and stops the counter exactly at a programmed terminal value.
module counter_run_ctrl #(
    parameter int WIDTH    = 4,
    parameter int RELOAD_W = 8
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic                pause_i,
    input  logic                reload_mode_i,
    input  logic [WIDTH-1:0]    terminal_i,
    input  logic [WIDTH-1:0]    counter_value_i,
    output logic                counter_enable_o,
    output logic                counter_clear_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [RELOAD_W-1:0] reload_count_o
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        PAUSE,
        DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   term_q;
    logic               mode_q;
    logic [WIDTH-1:0]   term_minus_one;
    logic               at_terminal;

    // The edge that leaves RUN still increments the counter, so stop one short.
    assign term_minus_one = term_q - 1'b1;
    assign at_terminal    = (counter_value_i >= term_minus_one);

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_i && !stop_i) begin
                    next_state = CLEAR;
                end
            end
            CLEAR: begin
                if (stop_i) begin
                    next_state = IDLE;
                end else if (term_q == '0) begin
                    next_state = DONE;
                end else begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (stop_i) begin
                    next_state = IDLE;
                end else if (at_terminal) begin
                    next_state = DONE;
                end else if (pause_i) begin
                    next_state = PAUSE;
                end
            end
            PAUSE: begin
                if (stop_i) begin
                    next_state = IDLE;
                end else if (!pause_i) begin
                    next_state = RUN;
                end
            end
            DONE: begin
                if (stop_i || !mode_q) begin
                    next_state = IDLE;
                end else begin
                    next_state = CLEAR;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Outputs are flops loaded with the decode of the next state.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state            <= IDLE;
            term_q           <= '0;
            mode_q           <= 1'b0;
            reload_count_o   <= '0;
            counter_enable_o <= 1'b0;
            counter_clear_o  <= 1'b0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
        end else begin
            state            <= next_state;
            counter_enable_o <= (next_state == RUN);
            counter_clear_o  <= (next_state == CLEAR);
            busy_o           <= (next_state != IDLE);
            done_o           <= (next_state == DONE);
            if (state == IDLE && next_state == CLEAR) begin
                term_q         <= terminal_i;
                mode_q         <= reload_mode_i;
                reload_count_o <= '0;
            end else if (state == DONE && next_state == CLEAR) begin
                if (reload_count_o != '1) begin
                    reload_count_o <= reload_count_o + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Directed bench for counter_run_ctrl with a behavioural model of the
// board counter it drives.
module tb_counter_run_ctrl;

    localparam int WIDTH    = 4;
    localparam int RELOAD_W = 8;

    logic                clock_i;
    logic                reset_i;
    logic                start_i;
    logic                stop_i;
    logic                pause_i;
    logic                reload_mode_i;
    logic [WIDTH-1:0]    terminal_i;
    logic [WIDTH-1:0]    counter_value_i;
    logic                counter_enable_o;
    logic                counter_clear_o;
    logic                busy_o;
    logic                done_o;
    logic [RELOAD_W-1:0] reload_count_o;

    int compared;
    int mismatched;

    typedef struct {
        logic       rst;
        logic       start;
        logic       stop;
        logic       pause;
        logic       mode;
        logic [3:0] term;
        logic       en;
        logic       clr;
        logic       busy;
        logic       done;
        logic [7:0] reload;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs[31];

    counter_run_ctrl #(.WIDTH(WIDTH), .RELOAD_W(RELOAD_W)) dut (
        .clock_i          (clock_i),
        .reset_i          (reset_i),
        .start_i          (start_i),
        .stop_i           (stop_i),
        .pause_i          (pause_i),
        .reload_mode_i    (reload_mode_i),
        .terminal_i       (terminal_i),
        .counter_value_i  (counter_value_i),
        .counter_enable_o (counter_enable_o),
        .counter_clear_o  (counter_clear_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .reload_count_o   (reload_count_o)
    );

    initial begin
        clock_i = 1'b0;
        forever #5 clock_i = ~clock_i;
    end

    // Model of the board counter: own reset, synchronous clear, enable.
    always @(posedge clock_i) begin
        if (reset_i) begin
            counter_value_i <= '0;
        end else if (counter_clear_o) begin
            counter_value_i <= '0;
        end else if (counter_enable_o) begin
            counter_value_i <= counter_value_i + 1'b1;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle of inputs, then samples 1 time unit after the edge.
    task automatic applyStimulus(input logic rst, input logic start, input logic stop,
                                 input logic pause, input logic mode, input logic [3:0] term);
        reset_i       = rst;
        start_i       = start;
        stop_i        = stop;
        pause_i       = pause;
        reload_mode_i = mode;
        terminal_i    = term;
        @(posedge clock_i);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    function automatic vec_t mk(input logic rst, input logic start, input logic stop,
                                input logic pause, input logic mode, input logic [3:0] term,
                                input logic en, input logic clr, input logic busy,
                                input logic done, input logic [7:0] reload, input logic [3:0] cnt);
        vec_t v;
        v.rst = rst; v.start = start; v.stop = stop; v.pause = pause;
        v.mode = mode; v.term = term; v.en = en; v.clr = clr; v.busy = busy;
        v.done = done; v.reload = reload; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        int enables;
        int cycles;
        bit seen_done;
        string tag;

        compared      = 0;
        mismatched    = 0;
        reset_i       = 1'b1;
        start_i       = 1'b0;
        stop_i        = 1'b0;
        pause_i       = 1'b0;
        reload_mode_i = 1'b0;
        terminal_i    = '0;

        //            rst st sp pa md term   en cl bu dn rl cnt
        vecs[0]  = mk(1, 0, 0, 0, 0, 4'd0,   0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 0, 0, 0, 4'd5,   0, 1, 1, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 4'd0,   1, 0, 1, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 4'd0,   1, 0, 1, 0, 0, 1);
        vecs[4]  = mk(0, 0, 0, 0, 0, 4'd0,   1, 0, 1, 0, 0, 2);
        vecs[5]  = mk(0, 0, 0, 0, 0, 4'd0,   1, 0, 1, 0, 0, 3);
        vecs[6]  = mk(0, 0, 0, 0, 0, 4'd0,   1, 0, 1, 0, 0, 4);
        vecs[7]  = mk(0, 0, 0, 0, 0, 4'd0,   0, 0, 1, 1, 0, 5);
        vecs[8]  = mk(0, 0, 0, 0, 0, 4'd0,   0, 0, 0, 0, 0, 5);
        vecs[9]  = mk(0, 1, 0, 0, 0, 4'd0,   0, 1, 1, 0, 0, 5);
        vecs[10] = mk(0, 0, 0, 0, 0, 4'd0,   0, 0, 1, 1, 0, 0);
        vecs[11] = mk(0, 0, 0, 0, 0, 4'd0,   0, 0, 0, 0, 0, 0);
        vecs[12] = mk(0, 1, 1, 0, 0, 4'd4,   0, 0, 0, 0, 0, 0);
        vecs[13] = mk(0, 1, 0, 0, 0, 4'd6,   0, 1, 1, 0, 0, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 4'd0,   1, 0, 1, 0, 0, 0);
        vecs[15] = mk(0, 1, 0, 0, 0, 4'd1,   1, 0, 1, 0, 0, 1);
        vecs[16] = mk(0, 0, 0, 0, 0, 4'd0,   1, 0, 1, 0, 0, 2);
        vecs[17] = mk(0, 0, 0, 0, 0, 4'd0,   1, 0, 1, 0, 0, 3);
        vecs[18] = mk(0, 0, 0, 0, 0, 4'd0,   1, 0, 1, 0, 0, 4);
        vecs[19] = mk(0, 0, 1, 0, 0, 4'd0,   0, 0, 0, 0, 0, 5);
        vecs[20] = mk(0, 0, 0, 0, 0, 4'd0,   0, 0, 0, 0, 0, 5);
        vecs[21] = mk(0, 1, 0, 0, 0, 4'd2,   0, 1, 1, 0, 0, 5);
        vecs[22] = mk(0, 0, 0, 0, 0, 4'd0,   1, 0, 1, 0, 0, 0);
        vecs[23] = mk(0, 0, 0, 0, 0, 4'd0,   1, 0, 1, 0, 0, 1);
        vecs[24] = mk(0, 0, 0, 1, 0, 4'd0,   0, 0, 1, 1, 0, 2);
        vecs[25] = mk(0, 0, 0, 0, 0, 4'd0,   0, 0, 0, 0, 0, 2);
        vecs[26] = mk(0, 1, 0, 0, 0, 4'd9,   0, 1, 1, 0, 0, 2);
        vecs[27] = mk(0, 0, 0, 0, 0, 4'd0,   1, 0, 1, 0, 0, 0);
        vecs[28] = mk(0, 0, 0, 0, 0, 4'd0,   1, 0, 1, 0, 0, 1);
        vecs[29] = mk(1, 0, 0, 0, 0, 4'd0,   0, 0, 0, 0, 0, 0);
        vecs[30] = mk(0, 0, 0, 0, 0, 4'd0,   0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 31; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].start, vecs[i].stop,
                          vecs[i].pause, vecs[i].mode, vecs[i].term);
            tag = $sformatf("vec%0d", i);
            checkOutput({tag, ".enable"}, int'(counter_enable_o), int'(vecs[i].en));
            checkOutput({tag, ".clear"},  int'(counter_clear_o),  int'(vecs[i].clr));
            checkOutput({tag, ".busy"},   int'(busy_o),           int'(vecs[i].busy));
            checkOutput({tag, ".done"},   int'(done_o),           int'(vecs[i].done));
            checkOutput({tag, ".reload"}, int'(reload_count_o),   int'(vecs[i].reload));
            checkOutput({tag, ".count"},  int'(counter_value_i),  int'(vecs[i].cnt));
        end

        // Full-scale terminal: 15 enable cycles, no wrap.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd15);
        enables   = 0;
        seen_done = 1'b0;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            idleCycle();
            if (counter_enable_o) enables++;
            if (done_o) seen_done = 1'b1;
        end
        checkOutput("t15.done_seen", int'(seen_done), 1);
        checkOutput("t15.enables", enables, 15);
        checkOutput("t15.count_at_done", int'(counter_value_i), 15);
        idleCycle();
        checkOutput("t15.busy_after", int'(busy_o), 0);
        checkOutput("t15.count_after", int'(counter_value_i), 15);

        // Auto-reload, T=3: four periods of CLEAR + 3 RUN + DONE.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3);
        checkOutput("reload.start_clear", int'(counter_clear_o), 1);
        for (int r = 1; r <= 4; r++) begin
            for (int i = 0; i < 3; i++) begin
                idleCycle();
                checkOutput($sformatf("reload%0d.run%0d.enable", r, i), int'(counter_enable_o), 1);
                checkOutput($sformatf("reload%0d.run%0d.count", r, i), int'(counter_value_i), i);
            end
            idleCycle();
            checkOutput($sformatf("reload%0d.done", r), int'(done_o), 1);
            checkOutput($sformatf("reload%0d.done_count", r), int'(counter_value_i), 3);
            idleCycle();
            checkOutput($sformatf("reload%0d.clear", r), int'(counter_clear_o), 1);
            checkOutput($sformatf("reload%0d.reload_count", r), int'(reload_count_o), r);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        checkOutput("reload.stop_busy", int'(busy_o), 0);
        checkOutput("reload.stop_done", int'(done_o), 0);
        checkOutput("reload.held", int'(reload_count_o), 4);
        idleCycle();
        checkOutput("reload.held_later", int'(reload_count_o), 4);

        // Pause for 3 cycles at value 2 with T=8: done 3 edges late.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8);
        checkOutput("pause.reload_cleared", int'(reload_count_o), 0);
        idleCycle();
        idleCycle();
        idleCycle();
        checkOutput("pause.count_before", int'(counter_value_i), 2);
        for (int p = 0; p < 3; p++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
            checkOutput($sformatf("pause%0d.enable", p), int'(counter_enable_o), 0);
            checkOutput($sformatf("pause%0d.busy", p), int'(busy_o), 1);
            checkOutput($sformatf("pause%0d.count", p), int'(counter_value_i), 3);
        end
        cycles    = 6;
        seen_done = 1'b0;
        for (int c = 0; c < 30 && !seen_done; c++) begin
            idleCycle();
            cycles++;
            if (done_o) seen_done = 1'b1;
        end
        checkOutput("pause.done_seen", int'(seen_done), 1);
        checkOutput("pause.edges_to_done", cycles, 12);
        checkOutput("pause.final_count", int'(counter_value_i), 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
